// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Op codes, FSM states and helpers shared by the shift register.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic isShiftOp(input logic [2:0] op);
    return (op >= OP_SRL) && (op <= OP_ROL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_register_hs_if.sv
// ============================================================================
// Module      : shift_register_hs_if
// Description : Four-phase req/fin handshake bundle for the shift register.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface shift_register_hs_if #(
  parameter int Width = 32
);
  localparam int AmtWidth = $clog2(Width);

  logic                req;
  logic [2:0]          op;
  logic [AmtWidth-1:0] amt;
  logic [Width-1:0]    in;
  logic                fin;
  logic                busy;
  logic                carry;
  logic [Width-1:0]    out;

  modport master (output req, op, amt, in, input fin, busy, carry, out);
  modport slave  (input req, op, amt, in, output fin, busy, carry, out);
endinterface

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// Module      : shift_step
// Description : Combinational one-bit shift/rotate step with the bit moved out.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module shift_step
  import shift_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic [2:0]       op,
  input  logic [Width-1:0] value,
  output logic [Width-1:0] nextValue,
  output logic             bitOut
);

  always_comb begin
    nextValue = value;
    bitOut    = 1'b0;
    case (op)
      OP_SRL: begin nextValue = {1'b0, value[Width-1:1]};         bitOut = value[0];       end
      OP_SRA: begin nextValue = {value[Width-1], value[Width-1:1]}; bitOut = value[0];     end
      OP_SLL: begin nextValue = {value[Width-2:0], 1'b0};         bitOut = value[Width-1]; end
      OP_ROR: begin nextValue = {value[0], value[Width-1:1]};     bitOut = value[0];       end
      OP_ROL: begin nextValue = {value[Width-2:0], value[Width-1]}; bitOut = value[Width-1]; end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_register_hs.sv
// ============================================================================
// Module      : shift_register_hs
// Description : Handshaked load/shift/rotate register; iterative by default,
//               single-cycle barrel path when SHIFT_REGISTER_HS_BARREL_EN is set.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module shift_register_hs
  import shift_pkg::*;
#(
  parameter  int Width    = 32,
  localparam int AmtWidth = $clog2(Width)
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_register_hs_if.slave  bus
);

  state_t           r_state, w_nextState;
  logic [Width-1:0] r_out, w_nextOut;
  logic             r_carry, w_nextCarry;
  logic             r_fin;
  logic [Width-1:0] w_stepOut;
  logic             w_stepBit;

`ifdef SHIFT_REGISTER_HS_BARREL_EN
  logic [Width-1:0] w_stageVal [Width];
  logic             w_stageBit [Width];

  // Stage i holds the register shifted by i; stage 0 keeps carry so amt=0 leaves it alone.
  for (genvar i = 0; i < Width; i++) begin : g_chain
    logic [Width-1:0] w_val;
    logic             w_bit;
    if (i == 0) begin : g_first
      assign w_val = r_out;
      assign w_bit = r_carry;
    end else begin : g_next
      shift_step #(.Width(Width)) u_step (
        .op       (bus.op),
        .value    (g_chain[i-1].w_val),
        .nextValue(w_val),
        .bitOut   (w_bit)
      );
    end
    assign w_stageVal[i] = w_val;
    assign w_stageBit[i] = w_bit;
  end

  assign w_stepOut = w_stageVal[bus.amt];
  assign w_stepBit = w_stageBit[bus.amt];
  assign bus.busy  = 1'b0;
`else
  logic [2:0]          r_op, w_nextOp;
  logic [AmtWidth-1:0] r_count, w_nextCount;
  logic                r_busy;

  shift_step #(.Width(Width)) u_step (
    .op       (r_op),
    .value    (r_out),
    .nextValue(w_stepOut),
    .bitOut   (w_stepBit)
  );

  assign bus.busy = r_busy;
`endif

  always_comb begin
    w_nextState = r_state;
    w_nextOut   = r_out;
    w_nextCarry = r_carry;
`ifndef SHIFT_REGISTER_HS_BARREL_EN
    w_nextOp    = r_op;
    w_nextCount = r_count;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          w_nextState = S_DONE;
          if (bus.op == OP_LOAD) begin
            w_nextOut   = bus.in;
            w_nextCarry = 1'b0;
          end
`ifdef SHIFT_REGISTER_HS_BARREL_EN
          else if (isShiftOp(bus.op)) begin
            w_nextOut   = w_stepOut;
            w_nextCarry = w_stepBit;
          end
`else
          else if (isShiftOp(bus.op) && (bus.amt != '0)) begin
            w_nextOp    = bus.op;
            w_nextCount = bus.amt;
            w_nextState = S_BUSY;
          end
`endif
        end
      end
`ifndef SHIFT_REGISTER_HS_BARREL_EN
      S_BUSY: begin
        w_nextOut   = w_stepOut;
        w_nextCarry = w_stepBit;
        w_nextCount = r_count - AmtWidth'(1);
        if (r_count == AmtWidth'(1)) w_nextState = S_DONE;
      end
`endif
      S_DONE: begin
        if (!bus.req) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_carry <= 1'b0;
      r_fin   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_out   <= w_nextOut;
      r_carry <= w_nextCarry;
      r_fin   <= (w_nextState == S_DONE);
    end
  end

`ifndef SHIFT_REGISTER_HS_BARREL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= OP_NOP;
      r_count <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_op    <= w_nextOp;
      r_count <= w_nextCount;
      r_busy  <= (w_nextState == S_BUSY);
    end
  end
`endif

  assign bus.fin   = r_fin;
  assign bus.carry = r_carry;
  assign bus.out   = r_out;

endmodule

`default_nettype wire

// File: doc/shift_register_hs.md
Name: shift_register_hs

Overview:
- Clocked, parametrised successor to the save/right-shift handshake register.
- Width-generic register with load plus five shift/rotate modes and a runtime shift amount, all behind a single four-phase req/fin handshake.
- Shift is iterative, one bit per clock; an optional barrel path does it in one clock.
- Sits between datapath control FSMs and operand registers in the arithmetic units (multiplier/divider operand shifting).

Parameters:
- Width, 32, data width in bits; legal values ≥ 2.
- AmtWidth, $clog2(Width), width of the shift-amount port (derived; do not override).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  1  four-phase request; op/amt/in must be stable while req=1 and fin=0.
- op  input  3  operation code (see Behaviour).
- amt  input  AmtWidth  shift/rotate distance, 0..Width-1.
- in  input  Width  load data.
- fin  output  1  four-phase acknowledge.
- busy  output  1  high in BUSY state.
- carry  output  1  last bit shifted or rotated out.
- out  output  Width  register contents.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out=0, fin=0, busy=0, carry=0, internal counter=0. Asserting reset mid-operation aborts the operation immediately; no partial result is held.
- Op codes:
  - 000 NOP
  - 001 LOAD (out<=in)
  - 010 SRL (logical right, 0 fill)
  - 011 SRA (arithmetic right, MSB fill)
  - 100 SLL (logical left, 0 fill)
  - 101 ROR
  - 110 ROL
  - 111 reserved, executes as NOP.
- FSM states:
  - IDLE: fin=0. E0 is the first rising edge with req=1. At E0, op, amt and in are captured.
    - NOP, LOAD, or any shift with amt=0: operation completes at E0, go to DONE.
    - Otherwise: counter<=amt, go to BUSY.
  - BUSY: busy=1. Each edge applies one 1-bit step of the captured op, updates carry with the bit moved out, and decrements the counter. The edge that decrements the counter from 1 to 0 goes to DONE. An amt=n shift therefore lands at edge En, and fin is high after En.
  - DONE: fin=1. Stay while req=1. On the first edge with req=0, fin<=0 and go to IDLE. The next request is accepted no earlier than the following edge.
- Latency: NOP, LOAD and amt=0 give fin one edge after E0 becomes visible (registered). Shift by n≥1 gives fin after edge En.
- carry:
  - LOAD clears carry.
  - NOP and amt=0 shifts leave carry unchanged.
  - SRL/SRA/ROR: carry = final out[0] shifted out. SLL/ROL: carry = final out[Width-1] shifted out.
- out changes only on: LOAD at E0, BUSY step edges, or reset. It is stable in IDLE and DONE.
- req falling while BUSY is a protocol violation. The operation still completes, and fin is then high for exactly one cycle.
- Captured op/amt/in are used throughout the operation; input changes after E0 are ignored.
- Outputs are all registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SHIFT_REGISTER_HS_BARREL_EN.
- Defined: the BUSY state and counter are removed. All ops complete at E0 using a single-cycle barrel shifter: out<=shift(out, amt), and carry gets the last bit moved out (same rules as above). fin is high after E0 for every op, and busy is tied 0.
- Undefined: iterative behaviour exactly as above.
- Final out and carry values are identical in both builds; only latency differs.

Decomposition:
- Package shift_pkg:
  - op-code localparams OP_NOP, OP_LOAD, OP_SRL, OP_SRA, OP_SLL, OP_ROR, OP_ROL
  - state encodings S_IDLE, S_BUSY, S_DONE.
- Sub-module shift_step: combinational one-bit step, (op, value) -> (next value, bit out).
  - Reused by the iterative path.
  - Chained through amt in the barrel build.

Test Plan:
- Reset/LOAD: rst_n low mid-BUSY -> out=0, fin=0, busy=0 asynchronously. Then LOAD in=0xA5A5_A5A5 -> out=0xA5A5_A5A5 and fin after E0, carry=0.
- SRL vs SRA: out=0x8000_0010, SRL amt=4 -> out=0x0800_0001, carry=0, fin after E4. Reload and SRA amt=4 -> out=0xF800_0001.
- Rotate: out=0x0000_0001, ROR amt=1 -> out=0x8000_0000, carry=1. Then ROL amt=31 -> out=0x4000_0000, fin after E31.
- amt=0 / NOP / op=111: out unchanged, carry unchanged, fin after E0, busy never asserted.
- Handshake: hold req high 5 cycles after fin -> fin stays 1 and out stable. Drop req -> fin low next edge. req raised the same cycle fin falls -> not accepted until the following edge. req dropped during BUSY -> single-cycle fin pulse.
- Barrel build (SHIFT_REGISTER_HS_BARREL_EN): repeat scenarios 2–3 -> identical out/carry, fin after E0 for all ops.
